// File: rtl/master_sm_scheduler_if.sv
// ----------------------------------------------------------------------------
// master_sm_scheduler_if
// Bundles the scheduler's button, maze-link and display signals.
//   master : the scheduler itself (reads button/maze, drives state/display)
//   slave  : the surrounding board logic (button, maze wrapper, decoder)
// Signals:
//   BTNC          start/acknowledge button, debounced level
//   MAZE_STATUS   maze status (bit3 = win, bit2 = failed)
//   MAZE_DIGIT    maze display value
//   MASTER_STATE  0 START, 1 MAZE, 2 WIN, 3 LOSE
//   DIGIT_SEL     selected display digit, 0 = rightmost
//   BIN_OUT       value for the selected digit
//   DOT_OUT       decimal point for the selected digit, 1 = off
//   TIMEOUT       high in LOSE when the loss was caused by time expiry
// ----------------------------------------------------------------------------
interface master_sm_scheduler_if;
  logic       BTNC;
  logic [3:0] MAZE_STATUS;
  logic [3:0] MAZE_DIGIT;
  logic [1:0] MASTER_STATE;
  logic [1:0] DIGIT_SEL;
  logic [3:0] BIN_OUT;
  logic       DOT_OUT;
  logic       TIMEOUT;

  modport master (
    input  BTNC, MAZE_STATUS, MAZE_DIGIT,
    output MASTER_STATE, DIGIT_SEL, BIN_OUT, DOT_OUT, TIMEOUT
  );

  modport slave (
    output BTNC, MAZE_STATUS, MAZE_DIGIT,
    input  MASTER_STATE, DIGIT_SEL, BIN_OUT, DOT_OUT, TIMEOUT
  );
endinterface

// File: rtl/master_sm_scheduler.sv
// ----------------------------------------------------------------------------
// master_sm_scheduler
// Top-level game sequencer. Steps the maze sub-machine through
// START -> MAZE -> WIN/LOSE -> START, enforces a per-game BCD countdown and
// time-multiplexes the single 4-digit 7-segment display.
// Ports:
//   CLK    system clock, rising edge
//   RESET  asynchronous active-low reset
//   bus    master_sm_scheduler_if.master (button, maze link, display)
// Parameters:
//   REFRESH_DIV  clock cycles per displayed digit
//   TICK_DIV     clock cycles per countdown second
//   TIME_LIMIT   game time in seconds, 1..99
// ----------------------------------------------------------------------------
module master_sm_scheduler #(
  parameter int REFRESH_DIV = 100000,
  parameter int TICK_DIV    = 100000000,
  parameter int TIME_LIMIT  = 30
) (
  input  logic                  CLK,
  input  logic                  RESET,
  master_sm_scheduler_if.master bus
);

  localparam int REF_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [3:0] TL_TENS = 4'(TIME_LIMIT / 10);
  localparam logic [3:0] TL_ONES = 4'(TIME_LIMIT % 10);

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_MAZE  = 2'd1,
    ST_WIN   = 2'd2,
    ST_LOSE  = 2'd3
  } state_t;

  state_t              state_r;
  logic [3:0]          cd_tens_r;
  logic [3:0]          cd_ones_r;
  logic [TICK_W-1:0]   tick_cnt_r;
  logic                timeout_r;

  logic                btn_sync1_r;
  logic                btn_sync2_r;
  logic                btn_edge_r;
  logic                press_r;

  logic [REF_W-1:0]    ref_cnt_r;
  logic [1:0]          digit_sel_r;

  logic                tick_wrap_s;
  logic                ref_wrap_s;
  logic                cd_zero_s;
  logic [3:0]          bin_s;
  logic                dot_s;
  logic                unused_status_s;

  // BCD countdown step: a zero ones digit borrows from tens and becomes 9.
  function automatic logic [7:0] bcd_dec(input logic [3:0] tens, input logic [3:0] ones);
    logic [7:0] res;
    if (ones == 4'd0) begin
      res = {tens - 4'd1, 4'd9};
    end else begin
      res = {tens, ones - 4'd1};
    end
    return res;
  endfunction

  assign tick_wrap_s     = (tick_cnt_r == TICK_W'(TICK_DIV - 1));
  assign ref_wrap_s      = (ref_cnt_r == REF_W'(REFRESH_DIV - 1));
  assign cd_zero_s       = (cd_tens_r == 4'd0) && (cd_ones_r == 4'd0);
  assign unused_status_s = ^bus.MAZE_STATUS[1:0];

  // Button synchroniser and one-shot press; press_r is itself registered so a
  // rising BTNC before edge k changes the state at edge k+3.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      btn_sync1_r <= 1'b0;
      btn_sync2_r <= 1'b0;
      btn_edge_r  <= 1'b0;
      press_r     <= 1'b0;
    end else begin
      btn_sync1_r <= bus.BTNC;
      btn_sync2_r <= btn_sync1_r;
      btn_edge_r  <= btn_sync2_r;
      press_r     <= btn_sync2_r & ~btn_edge_r;
    end
  end

  // Master state machine with countdown, second tick and timeout flag.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_r    <= ST_START;
      cd_tens_r  <= TL_TENS;
      cd_ones_r  <= TL_ONES;
      tick_cnt_r <= '0;
      timeout_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_START: begin
          tick_cnt_r <= '0;
          if (press_r) begin
            state_r   <= ST_MAZE;
            cd_tens_r <= TL_TENS;
            cd_ones_r <= TL_ONES;
          end
        end
        ST_MAZE: begin
          if (tick_wrap_s) begin
            tick_cnt_r <= '0;
          end else begin
            tick_cnt_r <= tick_cnt_r + TICK_W'(1);
          end
          // Win beats fail beats timeout; the countdown freezes on exit.
          if (bus.MAZE_STATUS[3]) begin
            state_r    <= ST_WIN;
            tick_cnt_r <= '0;
          end else if (bus.MAZE_STATUS[2]) begin
            state_r    <= ST_LOSE;
            tick_cnt_r <= '0;
          end else if (tick_wrap_s) begin
            if (cd_zero_s) begin
              state_r   <= ST_LOSE;
              timeout_r <= 1'b1;
            end else begin
              {cd_tens_r, cd_ones_r} <= bcd_dec(cd_tens_r, cd_ones_r);
            end
          end
        end
        ST_WIN, ST_LOSE: begin
          tick_cnt_r <= '0;
          if (press_r) begin
            state_r   <= ST_START;
            timeout_r <= 1'b0;
            cd_tens_r <= TL_TENS;
            cd_ones_r <= TL_ONES;
          end
        end
        default: begin
          state_r    <= ST_START;
          cd_tens_r  <= TL_TENS;
          cd_ones_r  <= TL_ONES;
          tick_cnt_r <= '0;
          timeout_r  <= 1'b0;
        end
      endcase
    end
  end

  // Display refresh counter and digit scan, free-running in every state.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ref_cnt_r   <= '0;
      digit_sel_r <= 2'd0;
    end else if (ref_wrap_s) begin
      ref_cnt_r   <= '0;
      digit_sel_r <= digit_sel_r + 2'd1;
    end else begin
      ref_cnt_r   <= ref_cnt_r + REF_W'(1);
    end
  end

  // Digit content mux; combinational so value and dot never lag DIGIT_SEL.
  always_comb begin
    bin_s = 4'h0;
    dot_s = 1'b1;
    case (digit_sel_r)
      2'd0: bin_s = (state_r == ST_MAZE) ? bus.MAZE_DIGIT : 4'h0;
      2'd1: bin_s = cd_ones_r;
      2'd2: begin
        bin_s = cd_tens_r;
        dot_s = (state_r == ST_MAZE) ? 1'b0 : 1'b1;
      end
      2'd3: bin_s = {2'b00, state_r};
      default: begin
        bin_s = 4'h0;
        dot_s = 1'b1;
      end
    endcase
  end

  assign bus.MASTER_STATE = state_r;
  assign bus.TIMEOUT      = timeout_r;
  assign bus.DIGIT_SEL    = digit_sel_r;
  assign bus.BIN_OUT      = bin_s;
  assign bus.DOT_OUT      = dot_s;

endmodule

// File: doc/master_sm_scheduler.md
Name: master_sm_scheduler

Overview:
- Top-level master state machine for the linked-state-machine world.
- Sequences the maze sub-machine by driving MASTER_STATE, and enforces a per-game time limit.
- Owns the single 4-digit 7-segment display. It time-multiplexes the digits and chooses, per digit, whether the maze's digit, the countdown or a state code is shown.
- Sits between the board buttons, the maze wrapper and the 7-segment decoder (the decoder takes a digit select, a 4-bit value and a dot).

Parameters:
- REFRESH_DIV, 100000: clock cycles per displayed digit (1 kHz digit rate at 100 MHz).
- TICK_DIV, 100000000: clock cycles per countdown second.
- TIME_LIMIT, 30: game time in seconds. Legal range 1..99; loaded as 2-digit BCD.

Ports:
- CLK  input  1  system clock; all flops on rising edge.
- RESET  input  1  asynchronous, active-low reset.
- BTNC  input  1  start/acknowledge button; raw level, already debounced.
- MAZE_STATUS  input  4  status from maze machine: bit3 = exit reached (win), bit2 = failed. Other bits ignored.
- MAZE_DIGIT  input  4  maze machine's display value.
- MASTER_STATE  output  2  to maze wrapper: 0 START, 1 MAZE, 2 WIN, 3 LOSE.
- DIGIT_SEL  output  2  digit select to decoder; 0 = rightmost.
- BIN_OUT  output  4  value for selected digit.
- DOT_OUT  output  1  decimal point for selected digit; 1 = off.
- TIMEOUT  output  1  high while in LOSE because time expired (not maze failure).

Behaviour:
- Reset (RESET=0, async) forces:
  - MASTER_STATE=0, DIGIT_SEL=0, TIMEOUT=0.
  - Countdown = TIME_LIMIT in BCD.
  - Refresh and tick counters = 0.
  - Button synchroniser flops = 0.
- Reset released mid-game always restarts in START.
- Button path:
  - 2-flop synchroniser, then edge register; press = sync2 & ~edge_reg.
  - BTNC rising before edge k: press seen at edge k+2; MASTER_STATE changes at edge k+3.
  - A held button produces exactly one press.
- State machine (registered):
  - START -> MAZE on press. Countdown loaded with TIME_LIMIT; tick counter cleared.
  - MAZE -> WIN if MAZE_STATUS[3]=1.
  - MAZE -> LOSE if MAZE_STATUS[2]=1, or countdown == 00 at a tick (sets TIMEOUT=1).
  - Priority in the same cycle: win > fail > timeout. A press in MAZE is ignored.
  - WIN / LOSE -> START on press. TIMEOUT cleared; countdown reloaded to TIME_LIMIT.
- Countdown:
  - Tick counter counts 0..TICK_DIV-1 only in MAZE, and holds at 0 outside MAZE.
  - At wrap, the BCD countdown decrements: ones 0 borrows from tens, ones becomes 9.
  - When the countdown is already 00 at a tick, no decrement occurs and LOSE is taken.
  - Countdown freezes on entering WIN/LOSE. The frozen value is displayed.
- Display scheduler:
  - Refresh counter 0..REFRESH_DIV-1 runs in all states.
  - At wrap, DIGIT_SEL increments mod 4 (3 -> 0).
  - BIN_OUT and DOT_OUT are combinational from DIGIT_SEL, the registered state and the countdown, so there is zero skew against DIGIT_SEL.
- Digit map:
  - Digit 0: MAZE_DIGIT in MAZE; 0 otherwise.
  - Digit 1: countdown ones.
  - Digit 2: countdown tens.
  - Digit 3: {2'b00, MASTER_STATE}.
  - DOT_OUT=0 only on digit 2 while in MAZE (separator); 1 elsewhere.
- MASTER_STATE changes only on clock edges; the maze machine sees a stable value for a full cycle.

Test Plan:
Directed tests use REFRESH_DIV=4, TICK_DIV=10, TIME_LIMIT=3.
- Reset/scan: RESET low then high; no buttons.
  - All reset values as listed.
  - DIGIT_SEL steps 0,1,2,3,0 every 4 cycles.
  - Digits 1/2 show 3/0; digit 3 shows 0.
- Start latency: pulse BTNC high for 20 cycles.
  - MASTER_STATE=1 exactly 3 edges after the rise.
  - Only one transition occurs.
  - Digit 0 tracks MAZE_DIGIT=4'h7.
  - Dot low on digit 2.
- Win: in MAZE, assert MAZE_STATUS=4'b1000 at cycle 15.
  - MASTER_STATE=2 next edge; TIMEOUT=0.
  - Countdown frozen at 02.
  - A later press returns to 0 with countdown 03.
- Timeout: stay in MAZE, MAZE_STATUS=0.
  - Countdown 03 -> 02 -> 01 -> 00 at ticks 1..3.
  - At tick 4: MASTER_STATE=3, TIMEOUT=1.
  - Press -> START, TIMEOUT=0.
- Simultaneous events:
  - MAZE_STATUS=4'b1100 on the same edge as the timeout tick gives WIN.
  - MAZE_STATUS=4'b0100 alone gives LOSE with TIMEOUT=0.
- Async reset mid-game: RESET low for 1 ns between edges while in MAZE with countdown 01.
  - Outputs return immediately to reset values.
  - After release, machine is in START with countdown 03.
